// File: rtl/mm_pkg.sv
// mm_pkg: shared types and constants for the main-memory block responder.
// Holds the FSM state encoding, block/word widths and the storage init pattern.
package mm_pkg;

  localparam int BLOCK_W = 64;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mm_state_e;

  // Block b holds the byte addresses of its own words: {b*8+4, b*8}.
  function automatic logic [BLOCK_W-1:0] init_block(input int idx);
    logic [WORD_W-1:0] w0;
    w0 = WORD_W'(idx * 8);
    return {w0 + WORD_W'(4), w0};
  endfunction

endpackage

// File: rtl/mm_block_array.sv
// mm_block_array: DEPTH_BLOCKS x 64-bit block storage with one combinational
// read port. Contents reload to the address-pattern on reset. The write port
// only exists when MM_WRITE_EN is defined; otherwise storage is read-only.
module mm_block_array
  import mm_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 64,
  parameter int IDX_W        = $clog2(DEPTH_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BLOCK_W-1:0] rd_data
`ifdef MM_WRITE_EN
  ,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BLOCK_W-1:0] wr_data
`endif
);

  logic [BLOCK_W-1:0] mem_q [DEPTH_BLOCKS];
  logic [BLOCK_W-1:0] mem_d [DEPTH_BLOCKS];

  // Next storage contents: unchanged unless a block write is requested.
  always_comb begin
    mem_d = mem_q;
`ifdef MM_WRITE_EN
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
`endif
  end

  // Storage register; reset reloads every block with its init pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BLOCKS; i++) begin
        mem_q[i] <= init_block(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mm_block_responder.sv
// mm_block_responder: handshaked, latency-modelled block-fill responder.
// Accepts one request in IDLE, waits LATENCY cycles in WAIT, then holds the
// 64-bit block in RESP until the cache takes it. Counts completed responses.
// Optional feature: define MM_WRITE_EN to honour REQ_WE block writes.
module mm_block_responder
  import mm_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 64,
  parameter int LATENCY      = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [31:0]        REQ_ADDR,
  input  logic               REQ_WE,
  input  logic [BLOCK_W-1:0] REQ_WDATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [BLOCK_W-1:0] RSP_DATA,
  output logic [31:0]        RSP_ADDR,
  output logic [19:0]        CNT_ACCESS
);

  localparam int         IDX_W    = $clog2(DEPTH_BLOCKS);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  mm_state_e          state_q, state_d;
  logic [3:0]         lat_q, lat_d;
  logic [31:0]        addr_q, addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;
  logic [19:0]        cnt_q, cnt_d;
  logic [BLOCK_W-1:0] rd_data;
  logic [IDX_W-1:0]   blk_idx;
  logic               unused_in;

`ifdef MM_WRITE_EN
  logic               we_q, we_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic               wr_en;

  assign unused_in = ^REQ_ADDR[2:0];
`else
  assign unused_in = ^{REQ_WE, REQ_WDATA, REQ_ADDR[2:0]};
`endif

  // Upper index bits are dropped so out-of-range addresses wrap modulo depth.
  assign blk_idx = addr_q[3 +: IDX_W];

  mm_block_array #(
    .DEPTH_BLOCKS (DEPTH_BLOCKS),
    .IDX_W        (IDX_W)
  ) u_array (
    .clk     (CLK),
    .rst_n   (RESET),
    .rd_idx  (blk_idx),
    .rd_data (rd_data)
`ifdef MM_WRITE_EN
    ,
    .wr_en   (wr_en),
    .wr_idx  (blk_idx),
    .wr_data (wdata_q)
`endif
  );

  // FSM next state plus latency counter, response registers and access count.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
`ifdef MM_WRITE_EN
    we_d        = we_q;
    wdata_d     = wdata_q;
    wr_en       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          addr_d  = {REQ_ADDR[31:3], 3'b000};
          lat_d   = LAT_INIT;
          state_d = WAIT;
`ifdef MM_WRITE_EN
          we_d    = REQ_WE;
          wdata_d = REQ_WDATA;
`endif
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef MM_WRITE_EN
          // A write is acknowledged by echoing the block just written.
          wr_en      = we_q;
          rsp_data_d = we_q ? wdata_q : rd_data;
`else
          rsp_data_d = rd_data;
`endif
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + 20'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      lat_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= 20'd0;
`ifdef MM_WRITE_EN
      we_q        <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
`ifdef MM_WRITE_EN
      we_q        <= we_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign REQ_READY  = (state_q == IDLE);
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ADDR   = addr_q;
  assign CNT_ACCESS = cnt_q;

endmodule

// File: tb/tb_mm_block_responder.sv
// Testbench for mm_block_responder: scenario tasks with a response scoreboard.
module tb_mm_block_responder;

  localparam int LAT = 4;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        REQ_WE;
  logic [63:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [63:0] RSP_DATA;
  logic [31:0] RSP_ADDR;
  logic [19:0] CNT_ACCESS;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;
  int   cyc     = 0;

  mm_block_responder #(
    .DEPTH_BLOCKS (64),
    .LATENCY      (LAT)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WE     (REQ_WE),
    .REQ_WDATA  (REQ_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_DATA   (RSP_DATA),
    .RSP_ADDR   (RSP_ADDR),
    .CNT_ACCESS (CNT_ACCESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference block contents for an untouched storage index.
  function automatic logic [63:0] model_block(input int idx);
    logic [31:0] w0;
    w0 = 32'(idx * 8);
    return {w0 + 32'd4, w0};
  endfunction

  // Presents one request until accepted, then drops REQ_VALID.
  task automatic send_req(input logic [31:0] a, input logic we, input logic [63:0] wd,
                          output int acc, output bit to);
    int n;
    n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    REQ_WE    = we;
    REQ_WDATA = wd;
    while (!REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    to = (n >= 50);
    @(posedge CLK);
    #1;
    acc       = cyc;
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
  endtask

  // Waits (bounded) for RSP_VALID at a falling edge.
  task automatic wait_rsp(output int seen, output bit to);
    int n;
    n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    to   = !RSP_VALID;
    seen = cyc;
  endtask

  task automatic test_reset();
    RESET     = 1'b0;
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'd0;
    REQ_WE    = 1'b0;
    REQ_WDATA = 64'd0;
    RSP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
    total++;
    if (RSP_DATA !== 64'd0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", RSP_DATA); end
    total++;
    if (RSP_ADDR !== 32'd0) begin bad++; $display("FAIL reset_rsp_addr: got %h want 0", RSP_ADDR); end
    total++;
    if (CNT_ACCESS !== 20'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", CNT_ACCESS); end
    RESET = 1'b1;
    @(negedge CLK);
    total++;
    if (REQ_READY !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", REQ_READY); end
  endtask

  // One request with RSP_READY held high: latency, data, address, count.
  task automatic test_single_read(input string nm, input logic [31:0] a, input logic we,
                                  input logic [63:0] wd, input logic [63:0] exp_data);
    int   acc;
    int   seen;
    bit   to;
    exp_t e;
    RSP_READY = 1'b1;
    sb.push_back('{data: exp_data, addr: {a[31:3], 3'b000}});
    send_req(a, we, wd, acc, to);
    total++;
    if (to) begin bad++; $display("FAIL %s_accept: got no REQ_READY want accept", nm); end
    wait_rsp(seen, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s_rsp: got no RSP_VALID want response", nm);
      e = sb.pop_front();
      return;
    end
    total++;
    if (seen - acc !== LAT) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, seen - acc, LAT); end
    e = sb.pop_front();
    total++;
    if (RSP_DATA !== e.data) begin bad++; $display("FAIL %s_data: got %h want %h", nm, RSP_DATA, e.data); end
    total++;
    if (RSP_ADDR !== e.addr) begin bad++; $display("FAIL %s_addr: got %h want %h", nm, RSP_ADDR, e.addr); end
    @(negedge CLK);
    exp_cnt++;
    total++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1", nm, RSP_VALID, REQ_READY);
    end
    total++;
    if (CNT_ACCESS !== 20'(exp_cnt)) begin bad++; $display("FAIL %s_cnt: got %0d want %0d", nm, CNT_ACCESS, exp_cnt); end
  endtask

  // Response stalled by RSP_READY=0 while a second request waits.
  task automatic test_backpressure();
    int   acc;
    int   seen;
    int   hs;
    bit   to;
    exp_t e;
    RSP_READY = 1'b0;
    sb.push_back('{data: model_block(1), addr: 32'h8});
    send_req(32'h8, 1'b0, 64'd0, acc, to);
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_ADDR  = 32'h18;
    sb.push_back('{data: model_block(3), addr: 32'h18});
    wait_rsp(seen, to);
    total++;
    if (to || seen - acc !== LAT) begin bad++; $display("FAIL bp_latency: got %0d want %0d", seen - acc, LAT); end
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== e.data || RSP_ADDR !== e.addr || REQ_READY !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h a=%h rdy=%b want v=1 d=%h a=%h rdy=0",
                 i, RSP_VALID, RSP_DATA, RSP_ADDR, REQ_READY, e.data, e.addr);
      end
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    hs = cyc;
    exp_cnt++;
    total++;
    if (CNT_ACCESS !== 20'(exp_cnt) || REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL bp_handshake: got cnt=%0d rdy=%b want cnt=%0d rdy=1", CNT_ACCESS, REQ_READY, exp_cnt);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    wait_rsp(seen, to);
    total++;
    if (to || seen - hs !== LAT + 1) begin bad++; $display("FAIL bp_second_latency: got %0d want %0d", seen - hs, LAT + 1); end
    e = sb.pop_front();
    total++;
    if (RSP_DATA !== e.data || RSP_ADDR !== e.addr) begin
      bad++;
      $display("FAIL bp_second_data: got %h@%h want %h@%h", RSP_DATA, RSP_ADDR, e.data, e.addr);
    end
    @(negedge CLK);
    exp_cnt++;
    total++;
    if (CNT_ACCESS !== 20'(exp_cnt)) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", CNT_ACCESS, exp_cnt); end
  endtask

  task automatic test_write();
`ifdef MM_WRITE_EN
    test_single_read("wr08", 32'h8, 1'b1, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);
    test_single_read("rd0c", 32'hC, 1'b0, 64'd0, 64'hDEADBEEF_CAFEF00D);
`else
    test_single_read("wr08", 32'h8, 1'b1, 64'hDEADBEEF_CAFEF00D, 64'h0000000C_00000008);
    test_single_read("rd0c", 32'hC, 1'b0, 64'd0, 64'h0000000C_00000008);
`endif
  endtask

  // REQ_VALID held high across two requests: spacing is LATENCY+2.
  task automatic test_back_to_back();
    int   acc1;
    int   seen1;
    int   seen2;
    bit   to;
    exp_t e;
    RSP_READY = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_ADDR  = 32'h20;
    sb.push_back('{data: model_block(4), addr: 32'h20});
    @(posedge CLK);
    #1;
    acc1     = cyc;
    REQ_ADDR = 32'h30;
    sb.push_back('{data: model_block(6), addr: 32'h30});
    wait_rsp(seen1, to);
    total++;
    if (to || seen1 - acc1 !== LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", seen1 - acc1, LAT); end
    e = sb.pop_front();
    total++;
    if (RSP_DATA !== e.data) begin bad++; $display("FAIL b2b_first_data: got %h want %h", RSP_DATA, e.data); end
    @(posedge CLK);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    exp_cnt++;
    wait_rsp(seen2, to);
    total++;
    if (to || seen2 - seen1 !== LAT + 2) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", seen2 - seen1, LAT + 2); end
    e = sb.pop_front();
    total++;
    if (RSP_DATA !== e.data || RSP_ADDR !== e.addr) begin
      bad++;
      $display("FAIL b2b_second_data: got %h@%h want %h@%h", RSP_DATA, RSP_ADDR, e.data, e.addr);
    end
    @(negedge CLK);
    exp_cnt++;
    total++;
    if (CNT_ACCESS !== 20'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", CNT_ACCESS, exp_cnt); end
  endtask

  // Reset while WAITing: request dropped, registers cleared, storage reloaded.
  task automatic test_reset_midflight();
    int acc;
    int stale;
    bit to;
    RSP_READY = 1'b1;
    sb.push_back('{data: model_block(8), addr: 32'h40});
    send_req(32'h40, 1'b0, 64'd0, acc, to);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    total++;
    if (RSP_VALID !== 1'b0 || RSP_DATA !== 64'd0 || RSP_ADDR !== 32'd0 || CNT_ACCESS !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset_clear: got v=%b d=%h a=%h c=%0d want all 0", RSP_VALID, RSP_DATA, RSP_ADDR, CNT_ACCESS);
    end
    @(negedge CLK);
    RESET = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge CLK);
      if (RSP_VALID) stale++;
    end
    total++;
    if (stale !== 0) begin bad++; $display("FAIL mid_reset_stale: got %0d valid cycles want 0", stale); end
    total++;
    if (CNT_ACCESS !== 20'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d want 0", CNT_ACCESS); end
    test_single_read("post_rst_rd0", 32'h0, 1'b0, 64'd0, 64'h00000004_00000000);
    test_single_read("post_rst_rd08", 32'h8, 1'b0, 64'd0, 64'h0000000C_00000008);
  endtask

  initial begin
    test_reset();
    test_single_read("rd00", 32'h0, 1'b0, 64'd0, 64'h00000004_00000000);
    test_single_read("rd14", 32'h14, 1'b0, 64'd0, 64'h00000014_00000010);
    test_backpressure();
    test_single_read("wrap200", 32'h200, 1'b0, 64'd0, 64'h00000004_00000000);
    test_write();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
